// File: rtl/wb_master_arb_if.sv
// Bus bundle between the two Wishbone masters, the arbiter and the switch port.
// Signal suffixes are from the arbiter's point of view.
interface wb_master_arb_if;
    logic [15:0] m0_dat_i;
    logic [15:0] m0_dat_o;
    logic [19:0] m0_adr_i;
    logic [1:0]  m0_sel_i;
    logic        m0_we_i;
    logic        m0_cyc_i;
    logic        m0_stb_i;
    logic        m0_ack_o;

    logic [15:0] m1_dat_i;
    logic [15:0] m1_dat_o;
    logic [19:0] m1_adr_i;
    logic [1:0]  m1_sel_i;
    logic        m1_we_i;
    logic        m1_cyc_i;
    logic        m1_stb_i;
    logic        m1_ack_o;

    logic [15:0] s_dat_o;
    logic [19:0] s_adr_o;
    logic [1:0]  s_sel_o;
    logic        s_we_o;
    logic        s_cyc_o;
    logic        s_stb_o;
    logic [15:0] s_dat_i;
    logic        s_ack_i;

    // Arbiter side: serves both masters and drives the switch port.
    modport slave (
        input  m0_dat_i, m0_adr_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i,
        output m0_dat_o, m0_ack_o,
        input  m1_dat_i, m1_adr_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i,
        output m1_dat_o, m1_ack_o,
        output s_dat_o, s_adr_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
        input  s_dat_i, s_ack_i
    );

    // Environment side: the masters and the switch.
    modport master (
        output m0_dat_i, m0_adr_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i,
        input  m0_dat_o, m0_ack_o,
        output m1_dat_i, m1_adr_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i,
        input  m1_dat_o, m1_ack_o,
        input  s_dat_o, s_adr_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
        output s_dat_i, s_ack_i
    );
endinterface

// File: rtl/wb_master_arb.sv
// Two-master round-robin Wishbone arbiter with a bus watchdog.
// A granted master keeps the bus until its cyc drops; stalls end in a dummy ack.
module wb_master_arb #(
    parameter int TMO_W   = 5,
    parameter int TMO_MAX = 31
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    wb_master_arb_if.slave  bus,
    output logic [1:0]      gnt_o,
    output logic            tmo_o
);

    typedef enum logic [1:0] {IDLE, G0, G1} state_t;

    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_MAX);

    state_t           state_q;
    logic [1:0]       gnt_q;
    logic             last_q;
    logic [TMO_W-1:0] wdg_q;
    logic [TMO_W-1:0] wdg_d;
    logic             stb_raw;
    logic             tmo;

    // Grant FSM; last_q=1 means m1 was served last, so m0 wins the next tie.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.m0_cyc_i && bus.m1_cyc_i) begin
                        if (last_q) begin
                            state_q <= G0;
                            gnt_q   <= 2'b01;
                        end else begin
                            state_q <= G1;
                            gnt_q   <= 2'b10;
                        end
                    end else if (bus.m0_cyc_i) begin
                        state_q <= G0;
                        gnt_q   <= 2'b01;
                    end else if (bus.m1_cyc_i) begin
                        state_q <= G1;
                        gnt_q   <= 2'b10;
                    end
                end
                G0: begin
                    if (!bus.m0_cyc_i) begin
                        state_q <= IDLE;
                        gnt_q   <= 2'b00;
                        last_q  <= 1'b0;
                    end
                end
                G1: begin
                    if (!bus.m1_cyc_i) begin
                        state_q <= IDLE;
                        gnt_q   <= 2'b00;
                        last_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 2'b00;
                end
            endcase
        end
    end

    // Switch-port mux, watchdog expiry and ack/data return to the masters.
    always_comb begin
        bus.s_adr_o = '0;
        bus.s_sel_o = '0;
        bus.s_dat_o = '0;
        bus.s_we_o  = 1'b0;
        bus.s_cyc_o = 1'b0;
        stb_raw     = 1'b0;
        if (gnt_q[0]) begin
            bus.s_adr_o = bus.m0_adr_i;
            bus.s_sel_o = bus.m0_sel_i;
            bus.s_dat_o = bus.m0_dat_i;
            bus.s_we_o  = bus.m0_we_i;
            bus.s_cyc_o = bus.m0_cyc_i;
            stb_raw     = bus.m0_stb_i;
        end else if (gnt_q[1]) begin
            bus.s_adr_o = bus.m1_adr_i;
            bus.s_sel_o = bus.m1_sel_i;
            bus.s_dat_o = bus.m1_dat_i;
            bus.s_we_o  = bus.m1_we_i;
            bus.s_cyc_o = bus.m1_cyc_i;
            stb_raw     = bus.m1_stb_i;
        end
        // A real ack in the expiry cycle wins over the forced one.
        tmo = (wdg_q == TMO_LIM) && bus.s_cyc_o && stb_raw && !bus.s_ack_i;
        bus.s_stb_o  = stb_raw && !tmo;
        bus.m0_ack_o = gnt_q[0] && (bus.s_ack_i || tmo);
        bus.m1_ack_o = gnt_q[1] && (bus.s_ack_i || tmo);
        bus.m0_dat_o = tmo ? 16'hFFFF : bus.s_dat_i;
        bus.m1_dat_o = tmo ? 16'hFFFF : bus.s_dat_i;
        if (!(bus.s_cyc_o && stb_raw) || bus.s_ack_i || tmo) begin
            wdg_d = '0;
        end else begin
            wdg_d = wdg_q + 1'b1;
        end
    end

    // Watchdog counts wait-cycles of the current strobe.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wdg_q <= '0;
        end else begin
            wdg_q <= wdg_d;
        end
    end

    assign gnt_o = gnt_q;
    assign tmo_o = tmo;

endmodule

// File: tb/tb_wb_master_arb.sv
// Directed bench for wb_master_arb; expected acks go to a scoreboard queue
// that a negedge monitor drains whenever a master sees ack.
module tb_wb_master_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] gnt;
    logic       tmo;

    always #5 clk = ~clk;

    wb_master_arb_if bus ();

    wb_master_arb #(.TMO_W(5), .TMO_MAX(31)) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .bus     (bus),
        .gnt_o   (gnt),
        .tmo_o   (tmo)
    );

    typedef struct packed {
        logic [1:0]  who;
        logic [15:0] dat;
        logic        tmo;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] who, input logic [15:0] dat,
                        input logic t);
        exp_t e;
        e.who = who;
        e.dat = dat;
        e.tmo = t;
        sb.push_back(e);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.m0_dat_i = '0; bus.m0_adr_i = '0; bus.m0_sel_i = '0;
        bus.m0_we_i = 0; bus.m0_cyc_i = 0; bus.m0_stb_i = 0;
        bus.m1_dat_i = '0; bus.m1_adr_i = '0; bus.m1_sel_i = '0;
        bus.m1_we_i = 0; bus.m1_cyc_i = 0; bus.m1_stb_i = 0;
        bus.s_dat_i = '0; bus.s_ack_i = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_in();
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    // Monitor: every ack must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (bus.m0_ack_o || bus.m1_ack_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ack_unexpected got=%b want=none t=%0t",
                         {bus.m1_ack_o, bus.m0_ack_o}, $time);
            end else begin
                e = sb.pop_front();
                chk("ack_who", {30'd0, bus.m1_ack_o, bus.m0_ack_o}, {30'd0, e.who});
                chk("ack_dat", {16'd0, e.who[1] ? bus.m1_dat_o : bus.m0_dat_o},
                    {16'd0, e.dat});
                chk("ack_dat_same", {16'd0, bus.m1_dat_o}, {16'd0, bus.m0_dat_o});
                chk("ack_tmo", {31'd0, tmo}, {31'd0, e.tmo});
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle_in();
        nxt();
        nxt();
        @(negedge clk);
        chk("rst_gnt", {30'd0, gnt}, 32'd0);
        chk("rst_tmo", {31'd0, tmo}, 32'd0);
        chk("rst_sbus", {7'd0, bus.s_cyc_o, bus.s_stb_o, bus.s_we_o,
                         bus.s_sel_o, bus.s_adr_o}, 32'd0);
        chk("rst_sdat", {16'd0, bus.s_dat_o}, 32'd0);
        chk("rst_acks", {30'd0, bus.m1_ack_o, bus.m0_ack_o}, 32'd0);
        rst = 1'b0;

        // m0 single read, slave acks one cycle after grant.
        nxt();
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1;
        bus.m0_adr_i = 20'h00100; bus.m0_sel_i = 2'b11;
        nxt();
        @(negedge clk);
        chk("rd_gnt", {30'd0, gnt}, 32'd1);
        chk("rd_adr", {12'd0, bus.s_adr_o}, 32'h00100);
        chk("rd_cycstb", {30'd0, bus.s_cyc_o, bus.s_stb_o}, 32'd3);
        nxt();
        bus.s_ack_i = 1; bus.s_dat_i = 16'h1234;
        push(2'b01, 16'h1234, 1'b0);
        @(negedge clk);
        chk("rd_m1_ack", {31'd0, bus.m1_ack_o}, 32'd0);
        nxt();
        bus.s_ack_i = 0;
        bus.m0_cyc_i = 0; bus.m0_stb_i = 0;
        nxt();
        @(negedge clk);
        chk("rd_release", {30'd0, gnt}, 32'd0);

        // Tie after reset: m0 first, bubble, m1, then tie favours m0.
        do_reset();
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_adr_i = 20'h11111;
        bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_adr_i = 20'h22222;
        nxt();
        @(negedge clk);
        chk("tie_gnt0", {30'd0, gnt}, 32'd1);
        chk("tie_adr0", {12'd0, bus.s_adr_o}, 32'h11111);
        nxt();
        bus.s_ack_i = 1; bus.s_dat_i = 16'h0A0A;
        push(2'b01, 16'h0A0A, 1'b0);
        nxt();
        bus.s_ack_i = 0;
        bus.m0_cyc_i = 0; bus.m0_stb_i = 0;
        nxt();
        @(negedge clk);
        chk("tie_bubble", {30'd0, gnt}, 32'd0);
        nxt();
        @(negedge clk);
        chk("tie_gnt1", {30'd0, gnt}, 32'd2);
        chk("tie_adr1", {12'd0, bus.s_adr_o}, 32'h22222);
        nxt();
        bus.s_ack_i = 1; bus.s_dat_i = 16'h0B0B;
        push(2'b10, 16'h0B0B, 1'b0);
        nxt();
        bus.s_ack_i = 0;
        bus.m1_cyc_i = 0; bus.m1_stb_i = 0;
        nxt();
        @(negedge clk);
        chk("tie_bubble2", {30'd0, gnt}, 32'd0);
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1;
        bus.m1_cyc_i = 1; bus.m1_stb_i = 1;
        nxt();
        @(negedge clk);
        chk("tie2_gnt0", {30'd0, gnt}, 32'd1);
        bus.m0_cyc_i = 0; bus.m0_stb_i = 0;
        bus.m1_cyc_i = 0; bus.m1_stb_i = 0;
        nxt();
        nxt();

        // m1 write held against a competing m0 request.
        bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_we_i = 1;
        bus.m1_dat_i = 16'hBEEF; bus.m1_adr_i = 20'h0ABCD;
        nxt();
        @(negedge clk);
        chk("wr_gnt", {30'd0, gnt}, 32'd2);
        chk("wr_dat", {16'd0, bus.s_dat_o}, 32'hBEEF);
        chk("wr_we", {31'd0, bus.s_we_o}, 32'd1);
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_adr_i = 20'h00200;
        nxt();
        @(negedge clk);
        chk("wr_hold_gnt", {30'd0, gnt}, 32'd2);
        chk("wr_hold_dat", {16'd0, bus.s_dat_o}, 32'hBEEF);
        nxt();
        bus.s_ack_i = 1; bus.s_dat_i = 16'h0000;
        push(2'b10, 16'h0000, 1'b0);
        @(negedge clk);
        chk("wr_ack_gnt", {30'd0, gnt}, 32'd2);
        chk("wr_ack_dat", {16'd0, bus.s_dat_o}, 32'hBEEF);
        nxt();
        bus.s_ack_i = 0;
        bus.m1_cyc_i = 0; bus.m1_stb_i = 0; bus.m1_we_i = 0;
        @(negedge clk);
        chk("wr_last_gnt", {30'd0, gnt}, 32'd2);
        nxt();
        @(negedge clk);
        chk("wr_bubble", {30'd0, gnt}, 32'd0);
        nxt();
        @(negedge clk);
        chk("m0_after_wr", {30'd0, gnt}, 32'd1);
        chk("m0_after_adr", {12'd0, bus.s_adr_o}, 32'h00200);

        // No slave ack: forced ack on wait-cycle 31.
        push(2'b01, 16'hFFFF, 1'b1);
        for (int i = 1; i <= 31; i++) begin
            nxt();
            @(negedge clk);
            if (i == 30) begin
                chk("wd_pre_tmo", {31'd0, tmo}, 32'd0);
                chk("wd_pre_stb", {31'd0, bus.s_stb_o}, 32'd1);
            end
            if (i == 31) begin
                chk("wd_tmo", {31'd0, tmo}, 32'd1);
                chk("wd_stb_mask", {31'd0, bus.s_stb_o}, 32'd0);
            end
        end
        nxt();
        @(negedge clk);
        chk("wd_tmo_once", {31'd0, tmo}, 32'd0);
        bus.m0_cyc_i = 0; bus.m0_stb_i = 0;
        nxt();
        nxt();

        // Real ack in the expiry cycle wins.
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_adr_i = 20'h00300;
        nxt();
        @(negedge clk);
        chk("race_gnt", {30'd0, gnt}, 32'd1);
        for (int i = 1; i <= 31; i++) begin
            nxt();
            if (i == 31) begin
                bus.s_ack_i = 1; bus.s_dat_i = 16'h5A5A;
                push(2'b01, 16'h5A5A, 1'b0);
                @(negedge clk);
                chk("race_no_tmo", {31'd0, tmo}, 32'd0);
                chk("race_stb", {31'd0, bus.s_stb_o}, 32'd1);
            end
        end
        nxt();
        bus.s_ack_i = 0;
        bus.m0_cyc_i = 0; bus.m0_stb_i = 0;
        nxt();
        nxt();

        // Reset in the middle of a G1 access; late ack is ignored.
        bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_we_i = 1;
        bus.m1_adr_i = 20'h33333; bus.m1_dat_i = 16'h1111;
        nxt();
        @(negedge clk);
        chk("mrst_gnt", {30'd0, gnt}, 32'd2);
        for (int i = 0; i < 10; i++) nxt();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        bus.s_ack_i = 1; bus.s_dat_i = 16'h7777;
        @(negedge clk);
        chk("mrst_gnt0", {30'd0, gnt}, 32'd0);
        chk("mrst_sbus", {7'd0, bus.s_cyc_o, bus.s_stb_o, bus.s_we_o,
                          bus.s_sel_o, bus.s_adr_o}, 32'd0);
        chk("mrst_sdat", {16'd0, bus.s_dat_o}, 32'd0);
        chk("mrst_ack", {30'd0, bus.m1_ack_o, bus.m0_ack_o}, 32'd0);
        chk("mrst_tmo", {31'd0, tmo}, 32'd0);
        nxt();
        bus.s_ack_i = 0;
        @(negedge clk);
        chk("mrst_regrant", {30'd0, gnt}, 32'd2);
        bus.m1_cyc_i = 0; bus.m1_stb_i = 0; bus.m1_we_i = 0;
        nxt();
        nxt();
        nxt();

        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
